// File: rtl/serial_comparator_pkg.sv
// Shared types and constants for the MSB-first serial magnitude comparator.
package serial_comparator_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int CNT_BITS      = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    UNDECIDED = 2'd0,
    GT        = 2'd1,
    LT        = 2'd2
  } decision_t;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } result_t;

  // The first differing bit pair wins; equal pairs leave the verdict open.
  function automatic decision_t resolve(input decision_t current,
                                        input logic a, input logic b);
    if (current != UNDECIDED) return current;
    if (a && !b)              return GT;
    if (!a && b)              return LT;
    return UNDECIDED;
  endfunction

  // An operand pair that never differed is equal.
  function automatic result_t to_result(input decision_t d);
    result_t r;
    r.gt = (d == GT);
    r.lt = (d == LT);
    r.eq = (d == UNDECIDED);
    return r;
  endfunction

endpackage

// File: rtl/serial_comparator_bit_counter.sv
// Saturating count of serial bits consumed; holds at LIMIT instead of wrapping.
module bit_counter
  import serial_comparator_pkg::*;
#(
  parameter int LIMIT = WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                enable,
  output logic [CNT_BITS-1:0] count
);

  localparam logic [CNT_BITS-1:0] MAX_COUNT = CNT_BITS'(LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != MAX_COUNT)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/serial_comparator.sv
// Compares two WIDTH-bit operands arriving MSB first, one bit pair per clock.
module serial_comparator
  import serial_comparator_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                a_bit,
  input  logic                b_bit,
  output logic                busy,
  output logic                done,
  output logic                gt,
  output logic                lt,
  output logic                eq,
  output logic [CNT_BITS-1:0] bit_cnt
);

  localparam logic [CNT_BITS-1:0] LAST_INDEX = CNT_BITS'(WIDTH - 1);

  state_t    state;
  decision_t decision;
  decision_t next_decision;
  result_t   final_result;
  logic      accept;
  logic      last_sample;

  assign accept      = (state == IDLE) && start;
  assign last_sample = (state == COMPARE) && (bit_cnt == LAST_INDEX);

  // NOTE: every signal driven in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old one.
  always_comb begin
    next_decision = decision;
    if (state == COMPARE) begin
      next_decision = resolve(decision, a_bit, b_bit);
    end
    final_result = to_result(next_decision);
  end

  bit_counter #(
    .LIMIT (WIDTH)
  ) u_bit_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (state == COMPARE),
    .count  (bit_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      decision <= UNDECIDED;
      gt       <= 1'b0;
      lt       <= 1'b0;
      eq       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= COMPARE;
            decision <= UNDECIDED;
            gt       <= 1'b0;
            lt       <= 1'b0;
            eq       <= 1'b0;
          end
        end
        COMPARE: begin
          decision <= next_decision;
          // The result is published on the same edge that takes the last bit.
          if (last_sample) begin
            state <= DONE;
            gt    <= final_result.gt;
            lt    <= final_result.lt;
            eq    <= final_result.eq;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state == COMPARE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_comparator.sv
// Directed-vector bench for serial_comparator with WIDTH=8.
module tb_serial_comparator;
  import serial_comparator_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       a_bit;
  logic       b_bit;
  logic       busy;
  logic       done;
  logic       gt;
  logic       lt;
  logic       eq;
  logic [4:0] bit_cnt;

  int errors = 0;
  int checks = 0;

  // Observations captured by run_op.
  int          done_cycle;
  int          pulses;
  logic        res_gt, res_lt, res_eq;
  logic [4:0]  res_cnt;
  logic [12:0] busy_seen;

  serial_comparator #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a_bit   (a_bit),
    .b_bit   (b_bit),
    .busy    (busy),
    .done    (done),
    .gt      (gt),
    .lt      (lt),
    .eq      (eq),
    .bit_cnt (bit_cnt)
  );

  always #5 clk = ~clk;

  // Cycle 0 is the cycle with start high before the accepting edge; cycle c
  // is observed 1 time unit after the c-th edge that follows it.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic hold);
    #1;
    pulses     = 0;
    done_cycle = -1;
    busy_seen  = '0;
    res_gt = 1'bx; res_lt = 1'bx; res_eq = 1'bx; res_cnt = 'x;
    start = 1'b1;
    a_bit = 1'b0;
    b_bit = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      #1;
      busy_seen[c] = busy;
      if (done === 1'b1) begin
        pulses++;
        if (done_cycle < 0) begin
          done_cycle = c;
          res_gt  = gt;
          res_lt  = lt;
          res_eq  = eq;
          res_cnt = bit_cnt;
        end
      end
      start = hold;
      if (c <= 8) begin
        a_bit = a[8-c];
        b_bit = b[8-c];
      end else begin
        a_bit = 1'b0;
        b_bit = 1'b0;
      end
      @(posedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, gt, lt, eq} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000", {busy, done, gt, lt, eq});
    end
    checks++;
    if (bit_cnt !== 5'd0) begin
      errors++;
      $display("FAIL reset_bit_cnt: got %0d expected 0", bit_cnt);
    end
    checks++;
    if (dut.state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", dut.state, IDLE);
    end
    reset = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_gt();
    run_op(8'hA5, 8'h5A, 1'b0);
    checks++;
    if (done_cycle !== 9) begin
      errors++;
      $display("FAIL gt_done_cycle: got %0d expected 9", done_cycle);
    end
    checks++;
    if ({res_gt, res_lt, res_eq} !== 3'b100) begin
      errors++;
      $display("FAIL gt_result: got gt/lt/eq=%b expected 100", {res_gt, res_lt, res_eq});
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL gt_done_pulses: got %0d expected 1", pulses);
    end
    checks++;
    if (busy_seen[8:1] !== 8'hFF || busy_seen[9] !== 1'b0) begin
      errors++;
      $display("FAIL gt_busy_window: got %b expected busy=1 cycles 1..8, 0 at 9", busy_seen[9:1]);
    end
  endtask

  task automatic test_eq();
    run_op(8'h3C, 8'h3C, 1'b0);
    checks++;
    if ({res_gt, res_lt, res_eq} !== 3'b001) begin
      errors++;
      $display("FAIL eq_result: got gt/lt/eq=%b expected 001", {res_gt, res_lt, res_eq});
    end
    checks++;
    if (res_cnt !== 5'd8) begin
      errors++;
      $display("FAIL eq_bit_cnt_at_done: got %0d expected 8", res_cnt);
    end
    // Results and count must persist in IDLE until the next start.
    #1;
    checks++;
    if ({gt, lt, eq} !== 3'b001 || bit_cnt !== 5'd8) begin
      errors++;
      $display("FAIL eq_hold_after_done: got gt/lt/eq=%b cnt=%0d expected 001 cnt=8", {gt, lt, eq}, bit_cnt);
    end
  endtask

  task automatic test_lsb_only();
    run_op(8'h80, 8'h81, 1'b0);
    checks++;
    if ({res_gt, res_lt, res_eq} !== 3'b010) begin
      errors++;
      $display("FAIL lsb_lt_result: got gt/lt/eq=%b expected 010", {res_gt, res_lt, res_eq});
    end
    checks++;
    if (done_cycle !== 9) begin
      errors++;
      $display("FAIL lsb_done_cycle: got %0d expected 9", done_cycle);
    end
  endtask

  task automatic test_start_held();
    run_op(8'h00, 8'hFF, 1'b1);
    checks++;
    if ({res_gt, res_lt, res_eq} !== 3'b010) begin
      errors++;
      $display("FAIL held_lt_result: got gt/lt/eq=%b expected 010", {res_gt, res_lt, res_eq});
    end
    checks++;
    if (pulses !== 1 || done_cycle !== 9) begin
      errors++;
      $display("FAIL held_single_done: got pulses=%0d cycle=%0d expected pulses=1 cycle=9", pulses, done_cycle);
    end
    checks++;
    if (busy_seen[10] !== 1'b0 || busy_seen[11] !== 1'b1) begin
      errors++;
      $display("FAIL held_restart_from_idle: got busy c10=%b c11=%b expected 0 1", busy_seen[10], busy_seen[11]);
    end
    // Abort the restarted operation before moving on.
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_mid_reset();
    int late_done;
    int late_busy;
    #1;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      #1;
      start = 1'b0;
      a_bit = c[0];
      b_bit = ~c[0];
      @(posedge clk);
    end
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (dut.state !== IDLE) begin
      errors++;
      $display("FAIL abort_state: got %0d expected %0d", dut.state, IDLE);
    end
    checks++;
    if ({busy, done, gt, lt, eq} !== 5'b0 || bit_cnt !== 5'd0) begin
      errors++;
      $display("FAIL abort_outputs: got %b cnt=%0d expected 00000 cnt=0", {busy, done, gt, lt, eq}, bit_cnt);
    end
    reset = 1'b0;
    late_done = 0;
    late_busy = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) late_done++;
      if (busy === 1'b1) late_busy++;
    end
    checks++;
    if (late_done !== 0 || late_busy !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got done=%0d busy=%0d cycles expected 0 0", late_done, late_busy);
    end
  endtask

  task automatic test_reset_with_start();
    #1;
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || dut.state !== IDLE) begin
      errors++;
      $display("FAIL reset_priority: got busy=%b state=%0d expected busy=0 state=%0d", busy, dut.state, IDLE);
    end
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || bit_cnt !== 5'd0) begin
      errors++;
      $display("FAIL reset_priority_after: got busy=%b cnt=%0d expected 0 0", busy, bit_cnt);
    end
  endtask

  task automatic test_back_to_back();
    run_op(8'h01, 8'h00, 1'b0);
    checks++;
    if ({res_gt, res_lt, res_eq} !== 3'b100) begin
      errors++;
      $display("FAIL b2b_first_gt: got gt/lt/eq=%b expected 100", {res_gt, res_lt, res_eq});
    end
    run_op(8'hFE, 8'hFF, 1'b0);
    checks++;
    if ({res_gt, res_lt, res_eq} !== 3'b010 || res_cnt !== 5'd8) begin
      errors++;
      $display("FAIL b2b_second_lt: got gt/lt/eq=%b cnt=%0d expected 010 cnt=8", {res_gt, res_lt, res_eq}, res_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_gt();
    test_eq();
    test_lsb_only();
    test_start_held();
    test_mid_reset();
    test_reset_with_start();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
